// File: rtl/pwm_capture.sv
// Pulse-train capture: measures rise-to-rise period and rise-to-fall high time of an
// asynchronous input, reports a 3-bit duty level and flags loss of signal.
module pwm_capture #(
    parameter int CNT_W       = 20,
    parameter int TIMEOUT     = 1000000,
    parameter int MIN_PERIOD  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pwm_in,
    output logic [CNT_W-1:0] o_high_count,
    output logic [CNT_W-1:0] o_period_count,
    output logic [2:0]       o_duty_level,
    output logic             o_meas_valid,
    output logic             o_signal_lost
);

    localparam logic [0:0]       S_IDLE    = 1'b0;
    localparam logic [0:0]       S_MEAS    = 1'b1;
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_MIN     = CNT_W'(MIN_PERIOD);
    localparam int               DW        = CNT_W + 3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_hlatch;
    logic [0:0]             r_state;

    logic             w_synced;
    logic             w_rise;
    logic             w_fall;
    logic             w_timeout;
    logic [CNT_W-1:0] w_period;
    logic [7:1]       w_ge;
    logic [2:0]       w_duty;

    assign w_synced  = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_synced & ~r_prev;
    assign w_fall    = ~w_synced & r_prev;
    assign w_period  = r_cnt + CNT_W'(1);
    assign w_timeout = (r_cnt == C_TIMEOUT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm_in};
            r_prev <= w_synced;
        end
    end

    // Counter saturates so a dead input cannot wrap into a bogus period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_hlatch <= '0;
        end else begin
            if (w_rise) begin
                r_cnt <= '0;
            end else if (!w_timeout) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_fall) begin
                r_hlatch <= w_period;
            end
        end
    end

    // Threshold k is met when high/period >= k/8; the duty level is how many are met.
    genvar gi;
    generate
        for (gi = 1; gi <= 7; gi++) begin : g_thresh
            assign w_ge[gi] = ({r_hlatch, 3'b000}) >= (DW'(gi) * DW'(w_period));
        end
    endgenerate

    always_comb begin
        w_duty = 3'd0;
        for (int k = 1; k <= 7; k++) begin
            w_duty = w_duty + 3'(w_ge[k]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            o_high_count   <= '0;
            o_period_count <= '0;
            o_duty_level   <= 3'd0;
            o_meas_valid   <= 1'b0;
            o_signal_lost  <= 1'b1;
        end else begin
            o_meas_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // First rise only opens a period; nothing complete to report yet.
                    if (w_rise) begin
                        r_state <= S_MEAS;
                    end
                end
                S_MEAS: begin
                    if (w_rise) begin
                        if (w_period >= C_MIN) begin
                            o_period_count <= w_period;
                            o_high_count   <= r_hlatch;
                            o_duty_level   <= w_duty;
                            o_meas_valid   <= 1'b1;
                            o_signal_lost  <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_state        <= S_IDLE;
                        o_signal_lost  <= 1'b1;
                        o_high_count   <= '0;
                        o_period_count <= '0;
                        o_duty_level   <= w_synced ? 3'd7 : 3'd0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized scoreboard bench for pwm_capture: a waveform-level model predicts each
// measurement / signal-loss event, and a monitor checks them as the DUT reports them.
module tb_pwm_capture;

    localparam int CNT_W   = 16;
    localparam int TO      = 4000;
    localparam int MINP    = 16;
    localparam int SYNC    = 2;

    logic             clk;
    logic             rst_n;
    logic             pwm;
    logic [CNT_W-1:0] high_count;
    logic [CNT_W-1:0] period_count;
    logic [2:0]       duty_level;
    logic             meas_valid;
    logic             signal_lost;

    pwm_capture #(
        .CNT_W(CNT_W), .TIMEOUT(TO), .MIN_PERIOD(MINP), .SYNC_STAGES(SYNC)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pwm_in(pwm),
        .o_high_count(high_count), .o_period_count(period_count),
        .o_duty_level(duty_level), .o_meas_valid(meas_valid),
        .o_signal_lost(signal_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit lost;
        int p;
        int h;
        int d;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Waveform-level model: time is counted in driven clock slots.
    int now = 0;
    bit m_lvl;
    bit m_meas;
    int m_rise;
    int m_h;

    function automatic int duty_of(input int h, input int p);
        int d;
        d = (8 * h) / p;
        return (d > 7) ? 7 : d;
    endfunction

    task automatic model_reset();
        m_lvl  = 1'b0;
        m_meas = 1'b0;
        m_rise = now;
        m_h    = 0;
    endtask

    task automatic add_seg(input bit lvl, input int len);
        ev_t e;
        if (lvl && !m_lvl) begin
            if (m_meas) begin
                int p;
                p = now - m_rise;
                if (p >= MINP) begin
                    e.lost = 1'b0; e.p = p; e.h = m_h; e.d = duty_of(m_h, p);
                    exp_q.push_back(e);
                end
            end
            m_meas = 1'b1;
            m_rise = now;
        end
        if (!lvl && m_lvl) begin
            m_h = (now - m_rise > TO + 1) ? TO + 1 : now - m_rise;
        end
        if (m_meas && (now + len > m_rise + TO + 1)) begin
            e.lost = 1'b1; e.p = 0; e.h = 0; e.d = lvl ? 7 : 0;
            exp_q.push_back(e);
            m_meas = 1'b0;
        end
        m_lvl = lvl;
        pwm   = lvl;
        repeat (len) begin
            @(negedge clk);
            now++;
        end
    endtask

    task automatic train(input int period, input int high, input int n);
        for (int i = 0; i < n; i++) begin
            add_seg(1'b1, high);
            add_seg(1'b0, period - high);
        end
    endtask

    // Monitor: compares every reported event against the head of the scoreboard.
    bit prev_mv   = 1'b0;
    bit prev_lost = 1'b1;
    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            prev_mv   = 1'b0;
            prev_lost = 1'b1;
        end else begin
            if (meas_valid) begin
                chk("mv_not_consecutive", int'(prev_mv), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_meas_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind_meas", 0, int'(e.lost));
                    chk("period_count", int'(period_count), e.p);
                    chk("high_count", int'(high_count), e.h);
                    chk("duty_level", int'(duty_level), e.d);
                    chk("lost_clear_on_meas", int'(signal_lost), 0);
                end
            end
            if (signal_lost && !prev_lost) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_signal_lost", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind_lost", 1, int'(e.lost));
                    chk("lost_period_count", int'(period_count), 0);
                    chk("lost_high_count", int'(high_count), 0);
                    chk("lost_duty_level", int'(duty_level), e.d);
                end
            end
            prev_mv   = meas_valid;
            prev_lost = signal_lost;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_high"}, int'(high_count), 0);
        chk({tag, "_period"}, int'(period_count), 0);
        chk({tag, "_duty"}, int'(duty_level), 0);
        chk({tag, "_mv"}, int'(meas_valid), 0);
        chk({tag, "_lost"}, int'(signal_lost), 1);
    endtask

    initial begin
        int p;
        int h;
        rst_n = 1'b0;
        pwm   = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        model_reset();

        // Idle low: nothing may be reported.
        add_seg(1'b0, TO + 10);
        chk_reset_outputs("idle");

        // 25% duty, then the period-800 duty sweep including the 12.5% boundary.
        train(1000, 250, 6);
        train(800, 4, 3);
        train(800, 100, 3);
        train(800, 400, 3);
        train(800, 700, 3);
        train(800, 799, 3);

        // Extra short pulses just before a rise make sub-MIN_PERIOD periods.
        for (int i = 0; i < 3; i++) begin
            add_seg(1'b1, 300);
            add_seg(1'b0, 690);
            add_seg(1'b1, 5);
            add_seg(1'b0, 5);
        end
        train(1000, 500, 3);

        // Random trains with occasional glitch periods.
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 4) == 0) p = $urandom_range(2, 15);
            else                           p = $urandom_range(20, 2000);
            h = $urandom_range(1, p - 1);
            add_seg(1'b1, h);
            add_seg(1'b0, p - h);
        end

        // Stuck high, then recover.
        train(600, 200, 3);
        add_seg(1'b1, TO + 500);
        train(700, 350, 4);

        // Asynchronous reset in the middle of a high phase.
        train(900, 450, 3);
        add_seg(1'b1, 100);
        chk("pre_reset_lost", int'(signal_lost), 0);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        add_seg(1'b1, 200);
        add_seg(1'b0, 300);
        train(500, 100, 3);

        // Final loss of signal while low, then the scoreboard must be drained.
        add_seg(1'b0, TO + 100);
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("final_lost", int'(signal_lost), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart to the rover's PWM generator: measures period and high time of an incoming pulse train.
- Typical sources: IR beacon detector output, or a loop-back of enableA/enableB for self-check.
- Reports cycle counts, a 3-bit duty level (same 0-7 scale as the speed state), and loss of signal.
- Sits beside the PWM and motor-driver blocks in the top level, clocked by the board clock.

Parameters:
- CNT_W, 20, width of all counters and count outputs; must satisfy 2^CNT_W > TIMEOUT.
- TIMEOUT, 1000000, clocks without a detected rising edge before signal loss is declared (10 ms at 100 MHz).
- MIN_PERIOD, 16, periods shorter than this many clocks are discarded as glitches.
- SYNC_STAGES, 2, number of flip-flops in the input synchronizer; minimum 2.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low; 0 = reset asserted.
- pwm_in  input  1  asynchronous pulse input.
- high_count  output  CNT_W  clocks from rising edge to falling edge of the last accepted period.
- period_count  output  CNT_W  clocks between the last two accepted rising edges.
- duty_level  output  3  floor(8*high/period), saturated to 7.
- meas_valid  output  1  one-clock pulse when a new measurement is loaded.
- signal_lost  output  1  level; 1 = no valid pulse train present.

Behaviour:
- Reset (async, reset=0):
  - All synchronizer flops, counters and the latch clear to 0; FSM goes to IDLE.
  - high_count=0, period_count=0, duty_level=0, meas_valid=0, signal_lost=1.
- Synchronizer: SYNC_STAGES-flop chain, then a prev register. A rise or fall is detected when the synced value differs from prev.
- Counter cnt:
  - Set to 0 on each detected rise; otherwise increments.
  - Saturates at TIMEOUT; never wraps.
  - Clean input therefore gives period = rise-to-rise distance in clocks exactly: at a rise, period = cnt+1.
- Falling edge: hlatch <= cnt+1 (rise-to-fall clocks).
- FSM:
  - IDLE: wait for a detected rise, then cnt <= 0 and go to MEAS. No output update, because the first period is incomplete.
  - MEAS, on a detected rise with P = cnt+1:
    - If P >= MIN_PERIOD: load period_count=P, high_count=hlatch and duty_level, pulse meas_valid, clear signal_lost.
    - If P < MIN_PERIOD: discard; outputs hold and no pulse. cnt still restarts.
  - MEAS, when cnt reaches TIMEOUT with no rise: go to IDLE and set signal_lost=1.
    - high_count and period_count clear to 0.
    - duty_level = 7 if the synced input is high (stuck on), 0 if it is low (stuck off).
- Duty arithmetic:
  - duty_level = count of k in 1..7 with 8*hlatch >= k*P, using (CNT_W+3)-bit compares.
  - Computed from the same hlatch and P values that are loaded, so all outputs are coherent in the same cycle.
- Latency: outputs and meas_valid update on the clock edge SYNC_STAGES clocks after the edge that first samples pwm_in high.
- Simultaneous events:
  - A rise and the TIMEOUT condition in the same cycle: the rise wins and is treated as a normal MEAS rise.
  - A rise and a fall cannot coincide on a single synced bit.
- Missing falling edge inside a period: hlatch keeps the last fall's value. With no fall since the previous rise, the previous value is reused. This cannot occur for a clean signal.
- Reset mid-period: the measurement in progress is dropped and the next measurement restarts from IDLE.
- meas_valid never asserts in two consecutive cycles. Outputs hold between updates.

Test Plan:
- Reset then idle pwm_in=0 for TIMEOUT+10 clocks -> signal_lost=1, counts 0, duty_level 0, meas_valid never high.
- 1 kHz, 25% duty at 100 MHz -> first meas_valid at 2nd rise; period_count=100000, high_count=25000, duty_level=2, signal_lost=0; one pulse per period afterwards.
- Sweep duty 0.5%, 12.5%, 50%, 87.5%, 99.9% with period 800 -> duty_level 0, 1, 4, 7, 7; the exact boundary 12.5% (high=100) gives 1, not 0.
- Inject a 5-clock extra pulse inside a 1000-clock period -> short periods below MIN_PERIOD discarded, no meas_valid for them, previously loaded values hold; clean pulses resume correct values.
- Run a valid train, then hold pwm_in high -> TIMEOUT clocks after the last rise: signal_lost=1, counts 0, duty_level=7; restart the train -> recovers at its 2nd rise.
- Assert reset mid-high-phase, release -> all outputs at reset values immediately (async); the first meas_valid occurs only after two fresh rises.
